// File: rtl/dram_responder.sv
// dram_responder: memory-side end of the per-hart DRAM request interface.
// Arbitrates NHARTS initiators round-robin and serves one load or store at a
// time from an internal 32-bit word array. Each access keeps w_dram_busy high
// for LATENCY cycles.
// Optional build macro: DRAM_RESP_STATS_EN adds load/store counters
// (w_rd_cnt, w_wr_cnt).
//
// Handshake: a one-cycle w_dram_we_t or w_dram_le pulse is accepted only when
// the block is IDLE. If both pulses arrive together, the store wins. Address,
// data and ctrl are latched on the accepting edge. w_dram_busy rises on the
// next cycle and stays high for exactly LATENCY cycles. w_dram_odata is valid
// from the cycle busy falls until the next load completes. Pulses seen while
// busy, or in the cycle busy falls, are ignored.
module dram_responder #(
   parameter int NHARTS    = 2,
   parameter int MEM_WORDS = 4096,
   parameter int LATENCY   = 4
) (
   input  logic              CLK,
   input  logic              RST_X,
   input  logic [NHARTS-1:0] w_req,
   output logic [31:0]       w_grant,
   input  logic [31:0]       w_dram_addr,
   input  logic [31:0]       w_dram_wdata,
   input  logic              w_dram_we_t,
   input  logic              w_dram_le,
   input  logic [2:0]        w_dram_ctrl,
   output logic [31:0]       w_dram_odata,
   output logic              w_dram_busy
`ifdef DRAM_RESP_STATS_EN
   ,
   output logic [31:0]       w_rd_cnt,
   output logic [31:0]       w_wr_cnt
`endif
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int GW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [GW-1:0]  grant_q, grant_d;
   logic [AW+1:0]  addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [2:0]     ctrl_q, ctrl_d;
   logic           store_q, store_d;
   logic [31:0]    odata_q, odata_d;

   logic           do_store;
   logic           do_load;
   logic [GW-1:0]  next_grant;
   logic           rr_found;
   logic [GW-1:0]  rr_cand;

   logic [31:0]    mem [MEM_WORDS];
   logic [AW-1:0]  word_idx;
   logic [31:0]    rd_word;
   logic [31:0]    wr_word;
   logic [31:0]    ld_value;
   logic [7:0]     ld_byte;
   logic [15:0]    ld_half;
   logic [4:0]     byte_off;

   // Address bits above the array index are deliberately ignored.
   logic           unused_addr_hi;
   assign unused_addr_hi = ^w_dram_addr[31:AW+2];

   assign word_idx = addr_q[AW+1:2];
   assign rd_word  = mem[word_idx];
   assign byte_off = {addr_q[1:0], 3'b000};

   // Round-robin pick: keep the owner while it requests, else scan forward
   // from owner+1 with wrap; with no requester the grant is unchanged.
   always_comb begin
      next_grant = grant_q;
      rr_found   = 1'b0;
      rr_cand    = '0;
      if (!w_req[grant_q]) begin
         for (int k = 1; k < NHARTS; k++) begin
            rr_cand = GW'((int'(grant_q) + k) % NHARTS);
            if (!rr_found && w_req[rr_cand]) begin
               next_grant = rr_cand;
               rr_found   = 1'b1;
            end
         end
      end
   end

   // Lane extraction and extension of the addressed word for loads.
   always_comb begin
      ld_byte  = rd_word[byte_off +: 8];
      ld_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
      ld_value = rd_word;
      case (ctrl_q)
         3'd0:    ld_value = {{24{ld_byte[7]}}, ld_byte};
         3'd4:    ld_value = {24'h000000, ld_byte};
         3'd1:    ld_value = {{16{ld_half[15]}}, ld_half};
         3'd5:    ld_value = {16'h0000, ld_half};
         default: ld_value = rd_word;
      endcase
   end

   // Read-modify-write merge of the store lanes into the addressed word.
   always_comb begin
      wr_word = rd_word;
      case (ctrl_q)
         3'd0: wr_word[byte_off +: 8] = wdata_q[7:0];
         3'd1: begin
            if (addr_q[1]) begin
               wr_word[31:16] = wdata_q[15:0];
            end else begin
               wr_word[15:0] = wdata_q[15:0];
            end
         end
         default: wr_word = wdata_q;
      endcase
   end

   // Next-state logic: accept pulses in IDLE, count latency in ACCESS, and
   // arbitrate only in IDLE cycles without a pulse.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ctrl_d   = ctrl_q;
      store_d  = store_q;
      odata_d  = odata_q;
      do_store = 1'b0;
      do_load  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_dram_we_t || w_dram_le) begin
               addr_d  = w_dram_addr[AW+1:0];
               wdata_d = w_dram_wdata;
               ctrl_d  = w_dram_ctrl;
               store_d = w_dram_we_t;
               cnt_d   = CW'(LATENCY - 1);
               state_d = S_ACCESS;
            end else begin
               grant_d = next_grant;
            end
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               if (store_q) begin
                  do_store = 1'b1;
               end else begin
                  do_load = 1'b1;
                  odata_d = ld_value;
               end
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and datapath registers; reset abandons any access in flight.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         ctrl_q  <= '0;
         store_q <= 1'b0;
         odata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ctrl_q  <= ctrl_d;
         store_q <= store_d;
         odata_q <= odata_d;
      end
   end

   // Backing array write port; contents survive reset.
   always_ff @(posedge CLK) begin
      if (do_store) begin
         mem[word_idx] <= wr_word;
      end
   end

`ifdef DRAM_RESP_STATS_EN
   logic [31:0] rd_cnt_q, wr_cnt_q;

   // Performed-access counters, wrapping modulo 2^32.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (do_load) begin
            rd_cnt_q <= rd_cnt_q + 32'd1;
         end
         if (do_store) begin
            wr_cnt_q <= wr_cnt_q + 32'd1;
         end
      end
   end

   assign w_rd_cnt = rd_cnt_q;
   assign w_wr_cnt = wr_cnt_q;
`endif

   assign w_grant      = 32'(grant_q);
   assign w_dram_busy  = (state_q == S_ACCESS);
   assign w_dram_odata = odata_q;

endmodule

// File: tb/tb_dram_responder.sv
// Testbench for dram_responder: directed steps followed by randomized
// accesses and arbitration. Expected results come from a byte-addressed
// reference memory and a round-robin arbitration rule.
module tb_dram_responder;

   localparam int NHARTS    = 2;
   localparam int MEM_WORDS = 4096;
   localparam int LATENCY   = 4;

   logic              CLK;
   logic              RST_X;
   logic [NHARTS-1:0] w_req;
   logic [31:0]       w_grant;
   logic [31:0]       w_dram_addr;
   logic [31:0]       w_dram_wdata;
   logic              w_dram_we_t;
   logic              w_dram_le;
   logic [2:0]        w_dram_ctrl;
   logic [31:0]       w_dram_odata;
   logic              w_dram_busy;
`ifdef DRAM_RESP_STATS_EN
   logic [31:0]       w_rd_cnt;
   logic [31:0]       w_wr_cnt;
`endif

   dram_responder #(
      .NHARTS   (NHARTS),
      .MEM_WORDS(MEM_WORDS),
      .LATENCY  (LATENCY)
   ) dut (
      .CLK         (CLK),
      .RST_X       (RST_X),
      .w_req       (w_req),
      .w_grant     (w_grant),
      .w_dram_addr (w_dram_addr),
      .w_dram_wdata(w_dram_wdata),
      .w_dram_we_t (w_dram_we_t),
      .w_dram_le   (w_dram_le),
      .w_dram_ctrl (w_dram_ctrl),
      .w_dram_odata(w_dram_odata),
      .w_dram_busy (w_dram_busy)
`ifdef DRAM_RESP_STATS_EN
      ,
      .w_rd_cnt    (w_rd_cnt),
      .w_wr_cnt    (w_wr_cnt)
`endif
   );

   // Reference state
   bit [7:0]    ref_mem [int];
   logic [31:0] exp_odata;
   int          exp_grant;
   int          exp_rd;
   int          exp_wr;
   int          n_cmp;
   int          n_fail;

   // Clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
         $error("%s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic int word_base(input logic [31:0] a);
      return int'((a >> 2) & (MEM_WORDS - 1)) * 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
      int          base;
      int          hl;
      logic [7:0]  b;
      logic [15:0] h;
      base = word_base(a);
      hl   = a[1] ? 2 : 0;
      b    = ref_mem[base + int'(a[1:0])];
      h    = {ref_mem[base + hl + 1], ref_mem[base + hl]};
      case (c)
         3'd0:    return {{24{b[7]}}, b};
         3'd4:    return {24'h0, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd5:    return {16'h0, h};
         default: return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
      endcase
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
      int base;
      int hl;
      base = word_base(a);
      hl   = a[1] ? 2 : 0;
      case (c)
         3'd0: ref_mem[base + int'(a[1:0])] = d[7:0];
         3'd1: begin
            ref_mem[base + hl]     = d[7:0];
            ref_mem[base + hl + 1] = d[15:8];
         end
         default: begin
            ref_mem[base]     = d[7:0];
            ref_mem[base + 1] = d[15:8];
            ref_mem[base + 2] = d[23:16];
            ref_mem[base + 3] = d[31:24];
         end
      endcase
   endtask

   // Owner keeps the bus while requesting; otherwise the first requester
   // after it in cyclic order; nobody requesting leaves it unchanged.
   function automatic int rr(input int g, input logic [NHARTS-1:0] req);
      int h;
      if (req[g]) return g;
      for (int k = 1; k < NHARTS; k++) begin
         h = (g + k) % NHARTS;
         if (req[h]) return h;
      end
      return g;
   endfunction

   task automatic idle_cycle(input logic [NHARTS-1:0] req, input string tag);
      w_req = req;
      @(posedge CLK); #1;
      exp_grant = rr(exp_grant, req);
      check(tag, w_grant, 32'(exp_grant));
   endtask

   // One access from the accepting edge through DONE back to IDLE.
   task automatic access(input bit st, input bit ld, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] c,
                         input string tag, output logic [31:0] od);
      int          cyc;
      logic [31:0] scramble;
      w_dram_addr  = a;
      w_dram_wdata = d;
      w_dram_ctrl  = c;
      w_dram_we_t  = st;
      w_dram_le    = ld;
      @(posedge CLK); #1;
      w_dram_we_t  = 1'b0;
      w_dram_le    = 1'b0;
      scramble     = $urandom;
      w_dram_addr  = scramble;
      w_dram_wdata = ~scramble;
      w_dram_ctrl  = scramble[2:0];
      cyc = 0;
      while (w_dram_busy === 1'b1 && cyc < 64) begin
         cyc++;
         @(posedge CLK); #1;
      end
      check({tag, "_busy_cycles"}, 32'(cyc), 32'(LATENCY));
      if (st) begin
         model_store(a, d, c);
         exp_wr++;
      end else if (ld) begin
         exp_odata = model_load(a, c);
         exp_rd++;
      end
      check({tag, "_odata"}, w_dram_odata, exp_odata);
      check({tag, "_grant"}, w_grant, 32'(exp_grant));
`ifdef DRAM_RESP_STATS_EN
      check({tag, "_rd_cnt"}, w_rd_cnt, 32'(exp_rd));
      check({tag, "_wr_cnt"}, w_wr_cnt, 32'(exp_wr));
`endif
      od = w_dram_odata;
      @(posedge CLK); #1;
   endtask

   initial begin
      logic [31:0] od;
      logic [31:0] rv;
      logic [31:0] ra;
      logic [2:0]  rc;
      bit          rst;
      n_cmp        = 0;
      n_fail       = 0;
      exp_odata    = 32'h0;
      exp_grant    = 0;
      exp_rd       = 0;
      exp_wr       = 0;
      RST_X        = 1'b0;
      w_req        = '0;
      w_dram_addr  = 32'h0;
      w_dram_wdata = 32'h0;
      w_dram_we_t  = 1'b0;
      w_dram_le    = 1'b0;
      w_dram_ctrl  = 3'd2;

      // Reset held while a load is pulsed: nothing may start
      @(posedge CLK); #1;
      w_dram_le = 1'b1;
      @(posedge CLK); #1;
      check("rst_busy_a", {31'h0, w_dram_busy}, 32'h0);
      @(posedge CLK); #1;
      w_dram_le = 1'b0;
      check("rst_busy_b", {31'h0, w_dram_busy}, 32'h0);
      check("rst_grant", w_grant, 32'h0);
      check("rst_odata", w_dram_odata, 32'h0);
      RST_X = 1'b1;
      @(posedge CLK); #1;
      check("post_rst_busy", {31'h0, w_dram_busy}, 32'h0);

      // Word, byte and halfword lanes for owner 0
      access(1, 0, 32'h10, 32'hDEADBEEF, 3'd2, "sw10", od);
      access(0, 1, 32'h10, 32'h0, 3'd2, "lw10", od);
      check("lw10_const", od, 32'hDEADBEEF);
      access(1, 0, 32'h11, 32'h00000080, 3'd0, "sb11", od);
      access(0, 1, 32'h11, 32'h0, 3'd0, "lb11", od);
      check("lb11_const", od, 32'hFFFFFF80);
      access(0, 1, 32'h11, 32'h0, 3'd4, "lbu11", od);
      check("lbu11_const", od, 32'h00000080);
      access(0, 1, 32'h10, 32'h0, 3'd2, "lw10b", od);
      check("lw10b_const", od, 32'hDEAD80EF);
      access(1, 0, 32'h12, 32'h00008001, 3'd1, "sh12", od);
      access(0, 1, 32'h12, 32'h0, 3'd1, "lh12", od);
      check("lh12_const", od, 32'hFFFF8001);
      access(0, 1, 32'h12, 32'h0, 3'd5, "lhu12", od);
      check("lhu12_const", od, 32'h00008001);

      // Arbitration: hold, hand over, frozen during an access
      idle_cycle(2'b11, "arb_hold0");
      idle_cycle(2'b10, "arb_move1");
      w_req = 2'b01;
      access(1, 0, 32'h20, 32'h01020304, 3'd2, "arb_sw", od);
      check("arb_before_idle", w_grant, 32'h1);
      idle_cycle(2'b01, "arb_after_done");
      idle_cycle(2'b00, "arb_none_hold");

      // Store and load together: store wins, odata unchanged
      access(1, 1, 32'h10, 32'hCAFEF00D, 3'd2, "both", od);
      check("both_odata_kept", od, 32'h00008001);
      access(0, 1, 32'h10, 32'h0, 3'd2, "both_lw", od);
      check("both_lw_const", od, 32'hCAFEF00D);

      // Reset in the middle of a store abandons it
      w_dram_addr  = 32'h10;
      w_dram_wdata = 32'h11111111;
      w_dram_ctrl  = 3'd2;
      w_dram_we_t  = 1'b1;
      @(posedge CLK); #1;
      w_dram_we_t = 1'b0;
      @(posedge CLK); #1;
      check("mid_busy_before", {31'h0, w_dram_busy}, 32'h1);
      #2 RST_X = 1'b0;
      #1;
      check("mid_rst_busy", {31'h0, w_dram_busy}, 32'h0);
      check("mid_rst_odata", w_dram_odata, 32'h0);
      check("mid_rst_grant", w_grant, 32'h0);
      exp_odata = 32'h0;
      exp_grant = 0;
      exp_rd    = 0;
      exp_wr    = 0;
      @(posedge CLK); #1;
      RST_X = 1'b1;
      w_req = '0;
      @(posedge CLK); #1;
      access(0, 1, 32'h10, 32'h0, 3'd2, "mid_lw_old", od);
      check("mid_lw_old_const", od, 32'hCAFEF00D);

      // Randomized phase over a small window with ignored upper address bits
      for (int i = 0; i < 16; i++) begin
         rv = $urandom;
         access(1, 0, 32'h100 + 32'(i * 4), rv, 3'd2, "init", od);
      end
      for (int i = 0; i < 40; i++) begin
         rv = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            idle_cycle(rv[NHARTS-1:0], "rnd_arb");
         end else begin
            ra  = (rv & 32'hFFFFC000) | (32'h100 + 32'($urandom_range(0, 63)));
            rst = ($urandom_range(0, 1) == 1);
            if (rst) begin
               rc = 3'($urandom_range(0, 2));
               access(1, 0, ra, $urandom, rc, "rnd_st", od);
            end else begin
               rc = 3'($urandom_range(0, 7));
               access(0, 1, ra, 32'h0, rc, "rnd_ld", od);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Memory-side end of the per-hart DRAM request interface (addr / wdata / odata / we_t / le / ctrl / busy) driven by the core/MMU wrapper.
- Arbitrates the interface between NHARTS initiators and publishes the owner's hart id on w_grant.
- Serves each granted load or store pulse from an internal word array with a fixed access latency.
- Handles byte/halfword lanes and load sign extension.

Parameters:
- NHARTS, 2, number of initiators competing for the interface (1..32).
- MEM_WORDS, 4096, depth of the 32-bit backing array; word index = addr[AW+1:2], where AW = $clog2(MEM_WORDS); upper address bits ignored.
- LATENCY, 4, cycles w_dram_busy stays high per access (>=1).

Ports:
- CLK  in  1  clock.
- RST_X  in  1  asynchronous active-low reset.
- w_req  in  NHARTS  per-hart "wants the bus" level.
- w_grant  out  32  hart id of current owner (zero-extended).
- w_dram_addr  in  32  byte address from the owner.
- w_dram_wdata  in  32  store data, right-aligned.
- w_dram_we_t  in  1  one-cycle store pulse.
- w_dram_le  in  1  one-cycle load pulse.
- w_dram_ctrl  in  3  RISC-V funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- w_dram_odata  out  32  load result; valid from the cycle busy falls until the next load completes.
- w_dram_busy  out  1  access in progress.

Behaviour:
- Reset (async, RST_X low): state IDLE, w_grant=0, w_dram_busy=0, w_dram_odata=0, latency counter=0. Array contents are not cleared. Reset mid-access abandons the access: a pending store is not written.
- States: IDLE, ACCESS, DONE.
- IDLE, we_t or le pulse sampled at a rising edge:
  - Latch addr, wdata and ctrl; load counter with LATENCY-1; go to ACCESS.
  - w_dram_busy=1 from the next cycle.
  - Both pulses in the same cycle: store wins, le is dropped.
- ACCESS: counter decrements each cycle. At 0, perform the access:
  - Store: read-modify-write of the lanes selected below.
  - Load: extract and extend the selected lanes into w_dram_odata.
  - Then go to DONE.
- DONE: w_dram_busy=0 in this cycle; return to IDLE next cycle.
- Busy timing: high for exactly LATENCY cycles; a new pulse is accepted earliest in the DONE cycle+1.
- Pulses while busy=1 or in DONE are ignored.
- Lanes:
  - Byte: lane = addr[1:0].
  - Halfword: lane = addr[1]; addr[0] ignored.
  - Word: addr[1:0] ignored.
  - Stores take wdata[7:0] / [15:0] / [31:0].
- Load extension: ctrl 0 and 1 sign-extend; ctrl 4 and 5 zero-extend; ctrl 2 passes the full word. Other ctrl codes behave as word.
- Arbitration (evaluated only in IDLE with no pulse that cycle):
  - If w_req[w_grant]=1, hold the grant.
  - Otherwise grant the next requesting hart, round-robin from w_grant+1 with wrap at NHARTS-1 -> 0.
  - If no requester, hold the current grant.
  - The grant changes at most once per cycle, never during ACCESS/DONE.
- Pulses are attributed to the current owner; the owner's signals are muxed upstream, outside this block.

Optional Feature:
- Macro DRAM_RESP_STATS_EN.
- Defined: adds outputs w_rd_cnt (32) and w_wr_cnt (32).
  - Each increments by 1 when a load or store (respectively) is performed in ACCESS.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with w_req=0 -> w_grant=0, busy=0, odata=0; hold RST_X low while pulsing le -> no busy.
- Owner 0: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> busy high exactly 4 cycles each; odata=0xDEADBEEF when busy falls.
- SB 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
- SH 0x12 data 0x8001, then LH 0x12 -> 0xFFFF8001; LHU -> 0x00008001.
- w_req=2'b11, grant 0, then drop w_req[0] -> w_grant=1 next cycle. Raise w_req[0], drop [1] during an access -> grant changes only after DONE.
- we_t and le in the same cycle -> store performed, odata unchanged. Reset mid-access -> busy=0 at once, later load shows old data. With DRAM_RESP_STATS_EN: w_wr_cnt=1, w_rd_cnt unchanged.
